// File: rtl/led_sched_pkg.sv
// Shared types and widths for the status-LED pattern scheduler.
package led_sched_pkg;

  localparam int PATTERN_W = 8;
  localparam int REP_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, restartable by a synchronous clear.
module led_tick_gen #(
  parameter int TICK_DIV = 2500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_MAX);

  // Next count: clear wins, otherwise wrap on the tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Round-robin owner of the single status LED: plays the granted 8-bit pattern
// REPEATS times at one bit per tick, then holds the LED dark for one tick.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 2500,
  parameter int REPEATS  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [PATTERN_W*NUM_REQ-1:0]   pattern_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           busy_o,
  output logic                           led_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEATS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [PATTERN_W-1:0]   pat_q, pat_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]       rep_q, rep_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   led_q, led_d;
  logic                   tick_s;
  logic                   tick_clr_s;
  logic [IDX_W-1:0]       pick_s;

  // Lowest requester above the last owner wins; otherwise wrap to the lowest one.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] hi_pick;
    logic [IDX_W-1:0] lo_pick;
    logic             hi_found;
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i] && (i > int'(last))) begin
        hi_pick  = IDX_W'(i);
        hi_found = 1'b1;
      end else if (r[i]) begin
        lo_pick = IDX_W'(i);
      end
    end
    return hi_found ? hi_pick : lo_pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign pick_s = rr_pick(req_i, last_q);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tick_clr_s),
    .tick_o  (tick_s)
  );

  // Next-state, counters and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    pat_d      = pat_q;
    bit_idx_d  = bit_idx_q;
    rep_d      = rep_q;
    done_d     = '0;
    tick_clr_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d    = PLAY;
          owner_d    = pick_s;
          pat_d      = pattern_i[pick_s*PATTERN_W +: PATTERN_W];
          bit_idx_d  = 3'd0;
          rep_d      = '0;
          tick_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (!req_i[owner_q]) begin
          // Owner withdrew: dark gap without a completion pulse.
          state_d    = GAP;
          last_d     = owner_q;
          tick_clr_s = 1'b1;
        end else if (tick_s) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if ((bit_idx_q == 3'd7) && (rep_q == REP_LAST)) begin
            state_d    = GAP;
            done_d     = onehot(owner_q);
            last_d     = owner_q;
            tick_clr_s = 1'b1;
          end else if (bit_idx_q == 3'd7) begin
            rep_d = rep_q + REP_W'(1);
          end else begin
            rep_d = rep_q;
          end
        end else begin
          state_d = PLAY;
        end
      end
      GAP: begin
        if (tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d    = IDLE;
        tick_clr_s = 1'b1;
      end
    endcase

    grant_d = (state_d == PLAY) ? onehot(owner_d) : '0;
    busy_d  = (state_d != IDLE);
    led_d   = (state_d == PLAY) ? pat_d[bit_idx_d] : 1'b0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      pat_q     <= '0;
      bit_idx_q <= 3'd0;
      rep_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      pat_q     <= pat_d;
      bit_idx_q <= bit_idx_d;
      rep_q     <= rep_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign led_o   = led_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench for led_pattern_scheduler with TICK_DIV=4, REPEATS=2, NUM_REQ=4.
module tb_led_pattern_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int TICK_DIV = 4;
  localparam int REPEATS  = 2;
  localparam int PLAY_CYC = 8 * REPEATS * TICK_DIV;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        led;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [3:0]  exp_grant_q[$];
  logic [3:0]  exp_done_q[$];
  logic [3:0]  prev_grant = 4'b0;
  logic [7:0]  pat_a5 = 8'hA5;

  led_pattern_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .TICK_DIV (TICK_DIV),
    .REPEATS  (REPEATS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .pattern_i (pattern),
    .grant_o   (grant),
    .done_o    (done),
    .busy_o    (busy),
    .led_o     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Waits for grant to fall (if high) and then rise; returns the rise cycle.
  task automatic wait_grant_rise(input int bound, output int t);
    int n;
    n = 0;
    while (grant != 4'b0 && n < bound) begin
      step(1);
      n++;
    end
    while (grant == 4'b0 && n < bound) begin
      step(1);
      n++;
    end
    check_eq("grant_wait", 32'(grant != 4'b0), 32'h1);
    t = cyc;
  endtask

  // Scoreboard: pops expected grant/done on each grant rise and each done pulse.
  always @(negedge clk) begin
    if (grant != 4'b0 && prev_grant == 4'b0) begin
      if (exp_grant_q.size() == 0) check_eq("grant_unexpected", 32'(grant), 32'h0);
      else check_eq("grant_order", 32'(grant), 32'(exp_grant_q.pop_front()));
    end
    if (done != 4'b0) begin
      if (exp_done_q.size() == 0) check_eq("done_unexpected", 32'(done), 32'h0);
      else check_eq("done_order", 32'(done), 32'(exp_done_q.pop_front()));
    end
    prev_grant = grant;
  end

  initial begin
    int t;
    int prev_t;
    int n;
    rst_n   = 1'b0;
    req     = 4'b0;
    pattern = 32'h0;
    step(2);
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_done",  32'(done),  32'h0);
    check_eq("rst_busy",  32'(busy),  32'h0);
    check_eq("rst_led",   32'(led),   32'h0);
    rst_n = 1'b1;
    step(1);
    check_eq("idle_busy", 32'(busy), 32'h0);

    // Single request, pattern A5 played twice.
    pattern[7:0] = 8'hA5;
    req = 4'b0001;
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    step(1);
    check_eq("t1_grant_lat", 32'(grant), 32'h1);
    check_eq("t1_busy", 32'(busy), 32'h1);
    for (int j = 0; j < PLAY_CYC; j++) begin
      check_eq("t1_led", 32'(led), 32'(pat_a5[3'((j / TICK_DIV) % 8)]));
      step(1);
    end
    check_eq("t1_done", 32'(done), 32'h1);
    check_eq("t1_grant_fall", 32'(grant), 32'h0);
    req = 4'b0;
    for (int j = 0; j < TICK_DIV; j++) begin
      check_eq("t1_gap_led", 32'(led), 32'h0);
      check_eq("t1_gap_busy", 32'(busy), 32'h1);
      step(1);
    end
    check_eq("t1_busy_fall", 32'(busy), 32'h0);

    // Round-robin over req=1011 from a fresh pointer.
    do_reset();
    pattern = {8'h0F, 8'h3C, 8'hC3, 8'h81};
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b1000); exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);  exp_done_q.push_back(4'b0010);
    exp_done_q.push_back(4'b1000);  exp_done_q.push_back(4'b0001);
    req = 4'b1011;
    prev_t = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant_rise(200, t);
      if (k > 0) check_eq("t2_period", 32'(t - prev_t), 32'(PLAY_CYC + TICK_DIV + 1));
      prev_t = t;
    end
    req = 4'b0001;
    n = 0;
    while (done == 4'b0 && n < 100) begin
      step(1);
      n++;
    end
    check_eq("t2_last_done", 32'(done), 32'h1);
    req = 4'b0;
    step(TICK_DIV + 1);
    check_eq("t2_idle", 32'(busy), 32'h0);

    // Abort: req[2] drops in the 10th play cycle.
    exp_grant_q.push_back(4'b0100);
    req = 4'b0100;
    step(1);
    check_eq("t3_grant", 32'(grant), 32'h4);
    step(9);
    check_eq("t3_still_granted", 32'(grant), 32'h4);
    req = 4'b0;
    step(1);
    check_eq("t3_grant_clr", 32'(grant), 32'h0);
    for (int j = 0; j < TICK_DIV; j++) begin
      check_eq("t3_gap_done", 32'(done), 32'h0);
      check_eq("t3_gap_led", 32'(led), 32'h0);
      check_eq("t3_gap_busy", 32'(busy), 32'h1);
      step(1);
    end
    check_eq("t3_idle", 32'(busy), 32'h0);

    // Pattern change mid-play has no effect on the latched pattern.
    pattern[15:8] = 8'hFF;
    exp_grant_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    req = 4'b0010;
    step(1);
    for (int j = 0; j < PLAY_CYC; j++) begin
      if (j == 20) pattern[15:8] = 8'h00;
      check_eq("t4_led", 32'(led), 32'h1);
      step(1);
    end
    check_eq("t4_done", 32'(done), 32'h2);
    req = 4'b0;
    step(TICK_DIV + 1);

    // req[1] rises as the FSM enters GAP: no grant until after IDLE.
    pattern[15:8] = 8'hFF;
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    req = 4'b0001;
    step(1);
    check_eq("t5_grant0", 32'(grant), 32'h1);
    step(PLAY_CYC);
    check_eq("t5_done", 32'(done), 32'h1);
    req = 4'b0010;
    exp_grant_q.push_back(4'b0010);
    for (int j = 0; j <= TICK_DIV; j++) begin
      check_eq("t5_no_grant", 32'(grant), 32'h0);
      step(1);
    end
    check_eq("t5_grant1", 32'(grant), 32'h2);

    // Asynchronous reset during repeat 1 of req[1].
    step(40);
    check_eq("t6_pre_led", 32'(led), 32'h1);
    #2;
    rst_n = 1'b0;
    req = 4'b1000;
    #1;
    check_eq("t6_rst_grant", 32'(grant), 32'h0);
    check_eq("t6_rst_led",   32'(led),   32'h0);
    check_eq("t6_rst_busy",  32'(busy),  32'h0);
    check_eq("t6_rst_done",  32'(done),  32'h0);
    step(2);
    exp_grant_q.push_back(4'b1000);
    rst_n = 1'b1;
    step(1);
    check_eq("t6_grant3", 32'(grant), 32'h8);
    req = 4'b0;
    step(10);
    check_eq("sb_empty", 32'(exp_grant_q.size() + exp_done_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
